// File: rtl/ula_pkg.sv
// Shared opcodes, FSM/iteration encodings and helpers for the sequential ULA.
// The ULA_SEQ_MUL_EN macro enables the MUL opcode path in the users of this package.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_OR  = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;

  typedef enum logic [1:0] {IT_SLL, IT_SRL, IT_MUL} iter_e;

  // Counter must hold the full width as a shift/step count.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ula_iter_unit.sv
// Accumulator + down-counter for 1-bit-per-cycle shifts and shift-add multiply.
// The multiplicand/multiplier registers exist only with ULA_SEQ_MUL_EN defined.
module ula_iter_unit import ula_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  iter_e            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    n,
  output logic [WIDTH-1:0] res,
  output logic             last
);

  iter_e            mode_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

`ifdef ULA_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand, mpl;
`else
  logic unused_b;
  assign unused_b = ^b;
`endif

  // res is the accumulator value after the step taken on this edge
  always_comb begin
    res = acc;
    case (mode_q)
      IT_SLL: res = acc << 1;
      IT_SRL: res = acc >> 1;
`ifdef ULA_SEQ_MUL_EN
      IT_MUL: res = mpl[0] ? acc + mcand : acc;
`endif
      default: res = acc;
    endcase
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q <= IT_SLL;
      acc    <= '0;
      cnt    <= '0;
`ifdef ULA_SEQ_MUL_EN
      mcand  <= '0;
      mpl    <= '0;
`endif
    end else if (load) begin
      mode_q <= mode;
      cnt    <= n;
`ifdef ULA_SEQ_MUL_EN
      acc    <= (mode == IT_MUL) ? '0 : a;
      mcand  <= a;
      mpl    <= b;
`else
      acc    <= a;
`endif
    end else if (step) begin
      acc <= res;
      cnt <= cnt - CW'(1);
`ifdef ULA_SEQ_MUL_EN
      mcand <= mcand << 1;
      mpl   <= mpl >> 1;
`endif
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Clocked ALU with start/done handshake; single-cycle ops plus iterative shifts.
// ULA_SEQ_MUL_EN adds an iterative unsigned multiply on opcode 111.
module ula_seq import ula_pkg::*; #(
  parameter int WIDTH      = 16,
  parameter bit SHIFT_ITER = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       controle,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] G,
  output logic             zero,
  output logic             neg,
  output logic             carry
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state;
  op_e              op;
  logic [WIDTH:0]   sum, dif;
  logic [CW-1:0]    n, it_n;
  logic [WIDTH-1:0] alu_res, it_res;
  logic             alu_c, is_shift, go_iter, go_mul, it_load, it_step, it_last;
  iter_e            it_mode;

  assign op  = op_e'(controle);
  assign sum = {1'b0, A} + {1'b0, bus};
  assign dif = {1'b0, A} - {1'b0, bus};
  // Oversized shift amounts saturate at WIDTH rather than wrapping.
  assign n   = (bus >= WIDTH'(WIDTH)) ? CW'(WIDTH) : bus[CW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: {alu_c, alu_res} = sum;
      OP_SUB: begin alu_res = dif[WIDTH-1:0]; alu_c = ~dif[WIDTH]; end
      OP_AND: alu_res = A & bus;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (A < bus)};
      OP_SLL: alu_res = A << bus;
      OP_SRL: alu_res = A >> bus;
      OP_OR:  alu_res = A | bus;
      default: alu_res = '0;
    endcase
  end

  assign is_shift = (op == OP_SLL) || (op == OP_SRL);
  assign go_iter  = SHIFT_ITER && is_shift && (n != '0);
`ifdef ULA_SEQ_MUL_EN
  assign go_mul   = (op == OP_MUL);
`else
  assign go_mul   = 1'b0;
`endif
  assign it_load  = (state == S_IDLE) && start && (go_iter || go_mul);
  assign it_step  = (state == S_SHIFT) || (state == S_MUL);
  assign it_mode  = go_mul ? IT_MUL : ((op == OP_SRL) ? IT_SRL : IT_SLL);
  assign it_n     = go_mul ? CW'(WIDTH) : n;

  ula_iter_unit #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clock  (clock),
    .resetn (resetn),
    .load   (it_load),
    .step   (it_step),
    .mode   (it_mode),
    .a      (A),
    .b      (bus),
    .n      (it_n),
    .res    (it_res),
    .last   (it_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      G     <= '0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (go_iter) begin
            state <= S_SHIFT;
            busy  <= 1'b1;
          end else if (go_mul) begin
            state <= S_MUL;
            busy  <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
            G     <= alu_res;
            zero  <= (alu_res == '0);
            neg   <= alu_res[WIDTH-1];
            carry <= alu_c;
          end
        end
        // Result registers load on the same edge the final step completes.
        S_SHIFT, S_MUL: if (it_last) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          G     <= it_res;
          zero  <= (it_res == '0);
          neg   <= it_res[WIDTH-1];
          carry <= 1'b0;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (WIDTH=16, SHIFT_ITER=1); honours ULA_SEQ_MUL_EN.
module tb_ula_seq;

  localparam int W = 16;

  logic         clock = 1'b0, resetn = 1'b1, start = 1'b0;
  logic [2:0]   controle = 3'b000;
  logic [W-1:0] A = '0, bus = '0;
  logic         busy, done, zero, neg, carry;
  logic [W-1:0] G;

  int n_cmp = 0, n_err = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] g;
    bit           z, n, c;
    int           lat;
  } exp_t;

  exp_t sb[$];

  ula_seq #(.WIDTH(W), .SHIFT_ITER(1'b1)) dut (
    .clock(clock), .resetn(resetn), .start(start), .controle(controle),
    .A(A), .bus(bus), .busy(busy), .done(done), .G(G),
    .zero(zero), .neg(neg), .carry(carry)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [W-1:0] g,
                              input bit z, input bit n, input bit c, input int lat);
    exp_t e;
    e.tag = tag; e.g = g; e.z = z; e.n = n; e.c = c; e.lat = lat;
    return e;
  endfunction

  // Reference behaviour for randomised operands.
  function automatic exp_t model(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] s;
    int       sh;
    sh = (int'(b) >= W) ? W : int'(b);
    e.tag = tag; e.c = 1'b0; e.lat = 1; e.g = '0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; e.g = s[W-1:0]; e.c = s[W]; end
      3'b001: begin e.g = a - b; e.c = (a >= b); end
      3'b010: e.g = a & b;
      3'b011: e.g = (a < b) ? W'(1) : W'(0);
      3'b100: begin e.g = (sh == W) ? '0 : (a << sh); e.lat = 1 + sh; end
      3'b101: begin e.g = (sh == W) ? '0 : (a >> sh); e.lat = 1 + sh; end
      3'b110: e.g = a | b;
      default: begin
`ifdef ULA_SEQ_MUL_EN
        e.g = a * b; e.lat = 1 + W;
`else
        e.g = '0;
`endif
      end
    endcase
    e.z = (e.g == '0);
    e.n = e.g[W-1];
    return e;
  endfunction

  // Drive one op, wait (bounded) for done, pop the scoreboard and compare.
  // poke: keep start asserted (with different operands) while busy and during done.
  task automatic run(input exp_t e, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit poke);
    exp_t x;
    int   lat, bcnt;
    bit   got;
    @(negedge clock);
    controle = op; A = a; bus = b; start = 1'b1;
    sb.push_back(e);
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (poke) begin controle = 3'b000; A = 16'h0001; bus = 16'h0001; start = 1'b1; end
      else start = 1'b0;
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    x = sb.pop_front();
    chk({x.tag, "/done"}, 32'(got), 32'd1);
    chk({x.tag, "/G"}, 32'(G), 32'(x.g));
    chk({x.tag, "/zero"}, 32'(zero), 32'(x.z));
    chk({x.tag, "/neg"}, 32'(neg), 32'(x.n));
    chk({x.tag, "/carry"}, 32'(carry), 32'(x.c));
    chk({x.tag, "/lat"}, 32'(lat), 32'(x.lat));
    chk({x.tag, "/busycyc"}, 32'(bcnt), 32'(x.lat - 1));
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk({x.tag, "/pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           k;

    #2 resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst/outs", 32'({busy, done, G, zero, neg, carry}), 32'd0);
    resetn = 1'b1;

    run(mk("add_ovf", 16'h0000, 1, 0, 1, 1), 3'b000, 16'hFFFF, 16'h0001, 0);
    run(mk("sub",     16'h0002, 0, 0, 1, 1), 3'b001, 16'h0005, 16'h0003, 0);
    run(mk("sub_neg", 16'hFFFE, 0, 1, 0, 1), 3'b001, 16'h0003, 16'h0005, 0);
    run(mk("slt_t",   16'h0001, 0, 0, 0, 1), 3'b011, 16'h0003, 16'h0005, 0);
    run(mk("slt_f",   16'h0000, 1, 0, 0, 1), 3'b011, 16'h0005, 16'h0003, 0);
    run(mk("and",     16'hF000, 0, 1, 0, 1), 3'b010, 16'hF0F0, 16'hFF00, 0);
    run(mk("sll4",    16'h0010, 0, 0, 0, 5), 3'b100, 16'h0001, 16'h0004, 1);
    run(mk("sll0",    16'h1234, 0, 0, 0, 1), 3'b100, 16'h1234, 16'h0000, 0);
    run(mk("srl20",   16'h0000, 1, 0, 0, 17), 3'b101, 16'h8000, 16'h0014, 0);
    run(mk("srl15",   16'h0001, 0, 0, 0, 16), 3'b101, 16'h8000, 16'h000F, 0);
    run(mk("srl16",   16'h0000, 1, 0, 0, 17), 3'b101, 16'hFFFF, 16'h0010, 0);
`ifdef ULA_SEQ_MUL_EN
    run(mk("mul",     16'h000F, 0, 0, 0, 17), 3'b111, 16'h0003, 16'h0005, 0);
    run(mk("mul_big", 16'h0001, 0, 0, 0, 17), 3'b111, 16'hFFFF, 16'hFFFF, 0);
`else
    run(mk("mul_off", 16'h0000, 1, 0, 0, 1), 3'b111, 16'h0003, 16'h0005, 0);
`endif
    run(mk("or",      16'h00FF, 0, 0, 0, 1), 3'b110, 16'h000F, 16'h00F0, 0);

    // Abort a long op mid-flight; outputs clear asynchronously and no done follows.
    @(negedge clock);
`ifdef ULA_SEQ_MUL_EN
    controle = 3'b111; A = 16'h0003; bus = 16'h0005;
`else
    controle = 3'b101; A = 16'h8000; bus = 16'h0010;
`endif
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("abort/busy_before", 32'(busy), 32'd1);
    chk("abort/G_before", 32'(G), 32'h00FF);
    resetn = 1'b0;
    #1;
    chk("abort/outs", 32'({busy, done, G, zero, neg, carry}), 32'd0);
    k = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) k++;
    end
    chk("abort/quiet", 32'(k), 32'd0);
    resetn = 1'b1;
    k = 0;
    repeat (20) begin
      @(negedge clock);
      if (done || busy) k++;
    end
    chk("abort/no_done", 32'(k), 32'd0);
    run(mk("add_post", 16'h0005, 0, 0, 0, 1), 3'b000, 16'h0002, 16'h0003, 0);

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = (op == 3'b100 || op == 3'b101) ? W'($urandom_range(0, 20)) : W'($urandom);
      run(model($sformatf("rnd%0d_op%0d", i, op), op, a, b), op, a, b, i[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
